// File: rtl/calc_input_fsm.sv
// calc_input_fsm: operand-entry sequencer for the 16-bit calculator.
// Buttons are synchronized, optionally debounced, and edge-detected into
// single-cycle enter/undo pulses. The pulses drive a four-state one-hot FSM
// that captures OP1, OP2 and ALU_ctrl from the slide switches.
// Optional feature: define BTN_DEBOUNCE_EN to compile in the per-button
// debounce counters (DEBOUNCE_CYCLES stable cycles before a level is accepted).
module calc_input_fsm #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [15:0] SW,
    input  logic        BTN_ENTER,
    input  logic        BTN_UNDO,
    output logic [15:0] OP1,
    output logic [15:0] OP2,
    output logic [2:0]  ALU_ctrl,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        WAIT_OP1 = 4'b0001,
        WAIT_OP2 = 4'b0010,
        WAIT_OP  = 4'b0100,
        SHOW_RES = 4'b1000
    } state_t;

    // Bit 0 is the enter button, bit 1 is the undo button.
    logic [1:0]  w_btn_raw;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  w_level;
    logic [1:0]  r_hist;
    logic [1:0]  r_armed;
    logic [1:0]  r_prime;
    logic [1:0]  w_pulse;
    logic        w_enter_p;
    logic        w_undo_p;

    state_t      r_state;
    logic [15:0] r_op1;
    logic [15:0] r_op2;
    logic [2:0]  r_alu;

    assign w_btn_raw = {BTN_UNDO, BTN_ENTER};

    // Two-flop synchronizer for both raw buttons.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       r_level;

    // Accept a new level only after it has differed from the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles; any return resets the count.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    // Rising-edge detect with arming. After reset every flop is zero, so a
    // button held through reset would look like a fresh 0->1 edge. A button
    // is armed only once the synchronizer holds a real sample (r_prime full)
    // and both the synchronized and accepted levels are low, i.e. it has
    // been seen released since reset.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_hist  <= '0;
            r_armed <= '0;
            r_prime <= '0;
        end else begin
            r_hist  <= w_level;
            r_prime <= {r_prime[0], 1'b1};
            r_armed <= r_armed | ({2{r_prime[1]}} & ~r_sync2 & ~w_level);
        end
    end

    assign w_pulse   = w_level & ~r_hist & r_armed;
    assign w_enter_p = w_pulse[0];
    assign w_undo_p  = w_pulse[1];

    // Entry sequencer: undo has priority over enter; illegal codes recover.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_OP1;
            r_op1   <= '0;
            r_op2   <= '0;
            r_alu   <= '0;
        end else begin
            case (r_state)
                WAIT_OP1: begin
                    if (!w_undo_p && w_enter_p) begin
                        r_op1   <= SW;
                        r_state <= WAIT_OP2;
                    end
                end
                WAIT_OP2: begin
                    if (w_undo_p) begin
                        r_state <= WAIT_OP1;
                    end else if (w_enter_p) begin
                        r_op2   <= SW;
                        r_state <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (w_undo_p) begin
                        r_state <= WAIT_OP2;
                    end else if (w_enter_p) begin
                        r_alu   <= SW[2:0];
                        r_state <= SHOW_RES;
                    end
                end
                SHOW_RES: begin
                    if (w_undo_p) begin
                        r_state <= WAIT_OP;
                    end else if (w_enter_p) begin
                        r_op1   <= '0;
                        r_op2   <= '0;
                        r_alu   <= '0;
                        r_state <= WAIT_OP1;
                    end
                end
                default: begin
                    r_op1   <= '0;
                    r_op2   <= '0;
                    r_alu   <= '0;
                    r_state <= WAIT_OP1;
                end
            endcase
        end
    end

    assign OP1      = r_op1;
    assign OP2      = r_op2;
    assign ALU_ctrl = r_alu;
    assign state    = r_state;

endmodule
